// File: rtl/job_sequencer_if.sv
// job_sequencer_if: handshake bundle between the job sequencer and its sub-blocks.
// The master drives the per-phase start levels, the shared RAM mux select and the
// RAM enable. Each sub-block answers on its own phase_end bit.
interface job_sequencer_if #(
    parameter int unsigned NUM_PHASES = 4,
    parameter int unsigned IDX_W      = 4
);
    logic [NUM_PHASES-1:0] phase_start;
    logic [NUM_PHASES-1:0] phase_end;
    logic [IDX_W-1:0]      phase_sel;
    logic                  ram_en;

    modport master (
        output phase_start,
        output phase_sel,
        output ram_en,
        input  phase_end
    );

    modport slave (
        input  phase_start,
        input  phase_sel,
        input  ram_en,
        output phase_end
    );
endinterface

// File: rtl/job_sequencer.sv
// job_sequencer: steps one job through NUM_PHASES sub-blocks in order. Each
// sub-block gets a level start and answers with a level end. Between phases the
// block waits a configurable gap. It also supports abort, auto-restart, a done
// pulse and a completed-job counter.
// Optional feature macro: JOB_SEQ_TIMEOUT_EN adds a per-phase watchdog that
// drives err/err_phase. Without it, err/err_phase are tied low and a phase may
// wait forever.
module job_sequencer #(
    parameter int unsigned NUM_PHASES = 4,
    parameter int unsigned GAP_CYCLES = 1,
    parameter int unsigned TIMEOUT_W  = 24,
    parameter int unsigned IDX_W      = 4
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 go,
    input  logic                 abort,
    input  logic                 auto_restart,
    input  logic [TIMEOUT_W-1:0] timeout_limit,
    job_sequencer_if.master      bus,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [IDX_W-1:0]     err_phase,
    output logic [15:0]          job_count
);

    localparam int unsigned GAP_W = 8;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_GAP,
        S_DONE,
        S_ERR
    } state_t;

    state_t                state;
    logic [IDX_W-1:0]      k;
    logic [GAP_W-1:0]      gap_cnt;
    logic [NUM_PHASES-1:0] start_q;
    logic [IDX_W-1:0]      sel_q;
    logic                  ram_en_q;

    // Sub-block side of the handshake comes straight from flops.
    assign bus.phase_start = start_q;
    assign bus.phase_sel   = sel_q;
    assign bus.ram_en      = ram_en_q;

    // start_q is one-hot at k while running, so masking with it honours only
    // the current phase's end and only once its start is already high.
    logic end_hit;
    logic last_phase;
    assign end_hit    = |(bus.phase_end & start_q);
    assign last_phase = (k == IDX_W'(NUM_PHASES - 1));

`ifdef JOB_SEQ_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] wdog_q;
    logic [TIMEOUT_W-1:0] wdog_inc;
    logic                 timeout_hit;

    // Fires on the cycle in which the count of idle RUN cycles reaches the limit.
    assign wdog_inc    = wdog_q + TIMEOUT_W'(1);
    assign timeout_hit = (timeout_limit != '0) && (wdog_inc == timeout_limit);
`else
    logic unused_timeout_limit;
    assign unused_timeout_limit = ^timeout_limit;
    assign err       = 1'b0;
    assign err_phase = '0;
`endif

    // Sequencer state, phase index and all registered outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= S_IDLE;
            k         <= '0;
            gap_cnt   <= '0;
            start_q   <= '0;
            sel_q     <= '0;
            ram_en_q  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            job_count <= '0;
`ifdef JOB_SEQ_TIMEOUT_EN
            wdog_q    <= '0;
            err       <= 1'b0;
            err_phase <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (abort && (state != S_IDLE)) begin
                // Abort beats go, end and timeout; err and job_count are kept.
                state    <= S_IDLE;
                k        <= '0;
                start_q  <= '0;
                sel_q    <= '0;
                ram_en_q <= 1'b0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (go && !abort) begin
                            state    <= S_ARM;
                            busy     <= 1'b1;
                            ram_en_q <= 1'b1;
                            k        <= '0;
                            sel_q    <= '0;
`ifdef JOB_SEQ_TIMEOUT_EN
                            err       <= 1'b0;
                            err_phase <= '0;
`endif
                        end
                    end

                    S_ARM: begin
                        state   <= S_RUN;
                        start_q <= NUM_PHASES'(1) << k;
`ifdef JOB_SEQ_TIMEOUT_EN
                        wdog_q  <= '0;
`endif
                    end

                    S_RUN: begin
                        if (end_hit) begin
                            start_q <= '0;
                            if (last_phase) begin
                                state <= S_DONE;
                            end else begin
                                // Select moves now so the RAM mux settles during the gap.
                                k       <= k + IDX_W'(1);
                                sel_q   <= k + IDX_W'(1);
                                gap_cnt <= GAP_W'(GAP_CYCLES);
                                state   <= S_GAP;
                            end
                        end
`ifdef JOB_SEQ_TIMEOUT_EN
                        else if (timeout_hit) begin
                            start_q   <= '0;
                            err       <= 1'b1;
                            err_phase <= k;
                            state     <= S_ERR;
                        end else begin
                            wdog_q <= wdog_inc;
                        end
`endif
                    end

                    // Always at least one all-low cycle between phases, plus GAP_CYCLES more.
                    S_GAP: begin
                        if (gap_cnt == '0) begin
                            state   <= S_RUN;
                            start_q <= NUM_PHASES'(1) << k;
`ifdef JOB_SEQ_TIMEOUT_EN
                            wdog_q  <= '0;
`endif
                        end else begin
                            gap_cnt <= gap_cnt - GAP_W'(1);
                        end
                    end

                    S_DONE: begin
                        done      <= 1'b1;
                        job_count <= job_count + CNT_W'(1);
                        k         <= '0;
                        sel_q     <= '0;
                        if (auto_restart) begin
                            state <= S_ARM;
                        end else begin
                            state    <= S_IDLE;
                            busy     <= 1'b0;
                            ram_en_q <= 1'b0;
                        end
                    end

                    // Timed-out job: release the RAM; auto_restart is not applied.
                    S_ERR: begin
                        state    <= S_IDLE;
                        k        <= '0;
                        sel_q    <= '0;
                        busy     <= 1'b0;
                        ram_en_q <= 1'b0;
                    end

                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
